// File: rtl/sparse_mac_pkg.sv
// -----------------------------------------------------------------------------
// sparse_mac_pkg
// Shared types for the sparse MAC datapath. The encoder and decoder both use
// the compressed SRAM entry layout defined here.
//   VALUE_W     : width of one dense element value
//   IDX_W       : width of the element index inside one vector
//   sram_data_t : compressed entry {index, value, last}
// -----------------------------------------------------------------------------
package sparse_mac_pkg;

    localparam int VALUE_W = 16;
    localparam int IDX_W   = 4;

    typedef struct packed {
        logic [IDX_W-1:0]   index;
        logic [VALUE_W-1:0] value;
        logic               last;
    } sram_data_t;

endpackage

// File: rtl/sparse_encoder_if.sv
// -----------------------------------------------------------------------------
// sparse_encoder_if
// Bundles the dense input stream, the compressed output stream and the length
// error flag of the sparse encoder.
//   dense_valid_i / dense_ready_o / dense_data_i / dense_last_i : dense beats
//   sram_valid_o  / sram_ready_i  / sram_data_o                  : entries
//   len_err_o                                                    : overflow
// Modports:
//   master : the encoder (accepts dense beats, produces compressed entries)
//   slave  : the environment (dense producer and compressed-entry consumer)
// -----------------------------------------------------------------------------
interface sparse_encoder_if;
    import sparse_mac_pkg::*;

    logic               dense_valid_i;
    logic               dense_ready_o;
    logic [VALUE_W-1:0] dense_data_i;
    logic               dense_last_i;
    logic               sram_valid_o;
    logic               sram_ready_i;
    sram_data_t         sram_data_o;
    logic               len_err_o;

    modport master (
        input  dense_valid_i, dense_data_i, dense_last_i, sram_ready_i,
        output dense_ready_o, sram_valid_o, sram_data_o, len_err_o
    );

    modport slave (
        output dense_valid_i, dense_data_i, dense_last_i, sram_ready_i,
        input  dense_ready_o, sram_valid_o, sram_data_o, len_err_o
    );

endinterface

// File: rtl/sparse_enc_fifo.sv
// -----------------------------------------------------------------------------
// sparse_enc_fifo
// Output FIFO of the sparse encoder, holding compressed entries.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// A push into a full FIFO is accepted when a pop happens in the same cycle
// (the pop frees the slot first).
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   push_i, data_i     : write request and entry
//   pop_i              : read request (ignored when empty)
//   full_o, empty_o    : occupancy flags
//   head_o             : entry at the head of the queue
// -----------------------------------------------------------------------------
module sparse_enc_fifo
    import sparse_mac_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  sram_data_t data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output sram_data_t head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    sram_data_t    mem [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == DEPTH_C);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push) wr_q <= wr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by the count.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_q] <= data_i;
    end

endmodule

// File: rtl/sparse_encoder.sv
// -----------------------------------------------------------------------------
// sparse_encoder
// Compresses a stream of dense vector elements into {index, value, last}
// entries, dropping zero elements. The most recent nonzero element is held in
// a one-entry pending register so that the final entry of a vector can be
// tagged last=1 once the vector's last beat has been seen. An all-zero vector
// produces a single terminator entry {0, 0, 1}.
// Ports:
//   mac_clk : sole clock (rising edge)
//   mac_rst : asynchronous active-low reset
//   bus     : sparse_encoder_if.master (dense in, compressed out, len_err_o)
// Parameter:
//   FIFO_DEPTH : output FIFO entries (power of two, >= 2)
// Optional feature:
//   SPARSE_ENCODER_LEN_CHECK_EN : when defined, len_err_o latches high when a
//   non-last beat is accepted at the maximum index; otherwise it is tied 0.
// -----------------------------------------------------------------------------
module sparse_encoder
    import sparse_mac_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              mac_clk,
    input  logic              mac_rst,
    sparse_encoder_if.master  bus
);

    typedef enum logic {RUN, FLUSH} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pend_vld_q, pend_vld_d;
    logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
    logic [VALUE_W-1:0] pend_val_q, pend_val_d;
    // Keeps dense_ready_o low while reset is asserted and until the first
    // clock edge after release.
    logic               run_en_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    sram_data_t         push_data;
    sram_data_t         fifo_head;
    logic               dense_ready;
    logic               beat_acc;

    assign dense_ready = run_en_q && (state_q == RUN) && !fifo_full;
    assign beat_acc    = bus.dense_valid_i && dense_ready;
    assign fifo_pop    = !fifo_empty && bus.sram_ready_i;

    assign bus.dense_ready_o = dense_ready;
    assign bus.sram_valid_o  = !fifo_empty;
    assign bus.sram_data_o   = fifo_head;

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        pend_vld_d       = pend_vld_q;
        pend_idx_d       = pend_idx_q;
        pend_val_d       = pend_val_q;
        fifo_push        = 1'b0;
        push_data        = '0;

        case (state_q)
            RUN: begin
                if (beat_acc) begin
                    idx_d = bus.dense_last_i ? '0 : idx_q + 1'b1;
                    if (bus.dense_data_i != '0) begin
                        // A new nonzero element retires the previous one,
                        // which cannot be the last entry of the vector.
                        if (pend_vld_q) begin
                            fifo_push       = 1'b1;
                            push_data.index = pend_idx_q;
                            push_data.value = pend_val_q;
                            push_data.last  = 1'b0;
                        end
                        pend_vld_d = 1'b1;
                        pend_idx_d = idx_q;
                        pend_val_d = bus.dense_data_i;
                    end
                    if (bus.dense_last_i) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!fifo_full) begin
                    fifo_push      = 1'b1;
                    push_data.last = 1'b1;
                    if (pend_vld_q) begin
                        push_data.index = pend_idx_q;
                        push_data.value = pend_val_q;
                    end
                    pend_vld_d = 1'b0;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst) begin
            state_q    <= RUN;
            idx_q      <= '0;
            pend_vld_q <= 1'b0;
            run_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_vld_q <= pend_vld_d;
            run_en_q   <= 1'b1;
        end
    end

    // Pending payload is qualified by pend_vld_q and needs no reset.
    always_ff @(posedge mac_clk) begin
        pend_idx_q <= pend_idx_d;
        pend_val_q <= pend_val_d;
    end

`ifdef SPARSE_ENCODER_LEN_CHECK_EN
    logic len_err_q;

    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst) begin
            len_err_q <= 1'b0;
        end else if (beat_acc && !bus.dense_last_i && (idx_q == '1)) begin
            len_err_q <= 1'b1;
        end
    end

    assign bus.len_err_o = len_err_q;
`else
    assign bus.len_err_o = 1'b0;
`endif

    sparse_enc_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (mac_clk),
        .rst_ni  (mac_rst),
        .push_i  (fifo_push),
        .data_i  (push_data),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_sparse_encoder.sv
// -----------------------------------------------------------------------------
// tb_sparse_encoder
// Directed bench for sparse_encoder. Stimulus pushes hand-computed entries
// into a scoreboard queue; a monitor pops and compares on every transfer and
// also checks that a stalled output holds its data.
// -----------------------------------------------------------------------------
module tb_sparse_encoder;
    import sparse_mac_pkg::*;

`ifdef SPARSE_ENCODER_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    sparse_encoder_if bus ();

    sparse_encoder #(
        .FIFO_DEPTH (2)
    ) dut (
        .mac_clk (clk),
        .mac_rst (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         fails  = 0;
    sram_data_t exp_q[$];

    function automatic sram_data_t mk(input int i, input int v, input bit l);
        sram_data_t e;
        e.index = i[IDX_W-1:0];
        e.value = v[VALUE_W-1:0];
        e.last  = l;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard compare on transfer, stability check while stalled.
    sram_data_t hold_data;
    bit         hold_vld = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                chk("stall_valid", 64'(bus.sram_valid_o), 64'd1);
                chk("stall_data", 64'(bus.sram_data_o), 64'(hold_data));
            end
            if (bus.sram_valid_o && bus.sram_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_entry: got 0x%0h expected none at %0t",
                             bus.sram_data_o, $time);
                end else begin
                    chk("entry", 64'(bus.sram_data_o), 64'(exp_q.pop_front()));
                end
            end
            hold_vld  = bus.sram_valid_o && !bus.sram_ready_i;
            hold_data = bus.sram_data_o;
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_beat(input int v, input bit l);
        int   n;
        logic acc;
        bus.dense_valid_i = 1'b1;
        bus.dense_data_i  = v[VALUE_W-1:0];
        bus.dense_last_i  = l;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.dense_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL beat_accept: got no ready expected ready within 100 cycles at %0t", $time);
        end
    endtask

    task automatic idle();
        bus.dense_valid_i = 1'b0;
        bus.dense_data_i  = '0;
        bus.dense_last_i  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.sram_valid_o) && n < 200) begin
            cycles(1);
            n++;
        end
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(3);
        chk("rst_ready", 64'(bus.dense_ready_o), 64'd0);
        chk("rst_valid", 64'(bus.sram_valid_o), 64'd0);
        chk("rst_len_err", 64'(bus.len_err_o), 64'd0);
        rst_n = 1'b1;
        cycles(1);
        chk("ready_after_rst", 64'(bus.dense_ready_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n             = 1'b0;
        bus.sram_ready_i  = 1'b1;
        idle();
        #1;
        do_reset();

        // [0,5,0,7]
        exp_q.push_back(mk(1, 5, 1'b0));
        exp_q.push_back(mk(3, 7, 1'b1));
        send_beat(0, 1'b0);
        send_beat(5, 1'b0);
        send_beat(0, 1'b0);
        send_beat(7, 1'b1);
        idle();
        drain("vec_0507");

        // [0,0,0]
        exp_q.push_back(mk(0, 0, 1'b1));
        send_beat(0, 1'b0);
        send_beat(0, 1'b0);
        send_beat(0, 1'b1);
        idle();
        drain("vec_zero");

        // [3,4] with the consumer stalled
        bus.sram_ready_i = 1'b0;
        exp_q.push_back(mk(0, 3, 1'b0));
        exp_q.push_back(mk(1, 4, 1'b1));
        send_beat(3, 1'b0);
        send_beat(4, 1'b1);
        idle();
        cycles(8);
        chk("full_ready", 64'(bus.dense_ready_o), 64'd0);
        chk("full_valid", 64'(bus.sram_valid_o), 64'd1);
        chk("full_head", 64'(bus.sram_data_o), 64'(mk(0, 3, 1'b0)));
        bus.sram_ready_i = 1'b1;
        drain("vec_stall");

        // [9] then [0,2] back to back
        exp_q.push_back(mk(0, 9, 1'b1));
        exp_q.push_back(mk(1, 2, 1'b1));
        send_beat(9, 1'b1);
        send_beat(0, 1'b0);
        send_beat(2, 1'b1);
        idle();
        drain("vec_b2b");

        // reset in the middle of [6,8,...], then [1]
        bus.sram_ready_i = 1'b0;
        send_beat(6, 1'b0);
        send_beat(8, 1'b0);
        idle();
        cycles(2);
        do_reset();
        bus.sram_ready_i = 1'b1;
        exp_q.push_back(mk(0, 1, 1'b1));
        send_beat(1, 1'b1);
        idle();
        drain("vec_after_rst");

        // 2^IDX_W + 1 beats of value 1: index wraps on the final beat
        for (int k = 0; k <= (1 << IDX_W); k++) begin
            if (k < (1 << IDX_W)) exp_q.push_back(mk(k, 1, 1'b0));
            else                  exp_q.push_back(mk(0, 1, 1'b1));
        end
        for (int k = 0; k <= (1 << IDX_W); k++) begin
            send_beat(1, k == (1 << IDX_W));
            chk("len_err", 64'(bus.len_err_o),
                64'(LEN_EN && (k >= (1 << IDX_W) - 1)));
        end
        idle();
        drain("vec_overflow");
        chk("len_err_sticky", 64'(bus.len_err_o), 64'(LEN_EN));
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sparse_encoder.md
SPARSE_ENCODER -- requirements
Module: sparse_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, output FIFO entries (power of two, >=2).
REQ-002 SHALL have port mac_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port mac_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port dense_valid_i  input  1  dense beat valid.
REQ-005 SHALL have port dense_ready_o  output  1  dense beat accepted when valid&&ready.
REQ-006 SHALL have port dense_data_i  input  VALUE_W  dense element value.
REQ-007 SHALL have port dense_last_i  input  1  final element of current vector.
REQ-008 SHALL have port sram_valid_o  output  1  compressed entry valid.
REQ-009 SHALL have port sram_ready_i  input  1  downstream (decoder) ready.
REQ-010 SHALL have port sram_data_o  output  sram_data_t  {index, value, last} entry.
REQ-011 SHALL have port len_err_o  output  1  index overflow flag (see Configuration).

Function
REQ-012 SHALL keep element counter idx (IDX_W bits) = position of next dense beat in vector; +1 per accepted beat; cleared to 0 after accepted last beat.
REQ-013 SHALL drop zero-valued beats (no entry) but still advance idx.
REQ-014 SHALL hold most recent nonzero element in one-entry pending register {idx, value}; on a new nonzero beat, push old pending (last=0) to FIFO and load new element.
REQ-015 SHALL use FSM states RUN and FLUSH; reset state RUN.
REQ-016 RUN: dense_ready_o = 1 only when FIFO not full; accepted beat with dense_last_i=1 SHALL transition to FLUSH (after any REQ-014 push/load that cycle).
REQ-017 FLUSH: dense_ready_o = 0; when FIFO not full, push pending with last=1 if pending valid, else push terminator {index 0, value 0, last 1}; clear pending; return to RUN same cycle edge.
REQ-018 Every vector SHALL produce exactly one entry with last=1, the final entry of that vector; all-zero vector yields only the terminator.
REQ-019 Entries SHALL leave in dense order with strictly increasing index within a vector.
REQ-020 sram_valid_o = FIFO non-empty; sram_data_o = FIFO head; pop on sram_valid_o&&sram_ready_i; push and pop in same cycle permitted when full (pop first).
REQ-021 sram_data_o SHALL hold stable while sram_valid_o=1 and sram_ready_i=0.
REQ-022 Latency: nonzero element emitted >=1 cycle after the next nonzero beat or last beat is accepted; FLUSH entry visible on sram_valid_o the cycle after the FLUSH push.
REQ-023 Throughput: one dense beat per cycle when downstream ready every cycle, except one FLUSH cycle per vector.

Reset
REQ-024 On mac_rst low: FSM=RUN, idx=0, pending invalid, FIFO empty, sram_valid_o=0, dense_ready_o=0 while asserted, len_err_o=0.
REQ-025 Reset mid-vector SHALL discard pending and FIFO contents; no partial entry emitted after release.
REQ-026 dense_ready_o SHALL go 1 the first cycle after reset release.

Configuration
REQ-027 Macro SPARSE_ENCODER_LEN_CHECK_EN defined: accepted non-last beat with idx=2^IDX_W-1 SHALL set len_err_o sticky until reset; idx wraps to 0; encoding continues.
REQ-028 Macro undefined: len_err_o tied 0, no check logic; idx wraps silently.

Structure
REQ-029 sram_data_t, VALUE_W, IDX_W SHALL come from sparse_mac_pkg, unchanged; no new package types.
REQ-030 Output FIFO SHALL be sub-module sparse_enc_fifo (parameterized depth, sram_data_t payload); FSM, counter, pending register in top.

Verification
REQ-031 Vector [0,5,0,7] last on 4th, ready=1 -> entries {1,5,0},{3,7,1}; no other entries.
REQ-032 Vector [0,0,0] -> single entry {0,0,1}.
REQ-033 Vector [3,4] with sram_ready_i=0 for 10 cycles -> dense_ready_o drops when FIFO full, sram_data_o stable {0,3,0}; after release {0,3,0},{1,4,1}.
REQ-034 Back-to-back vectors [9] then [0,2] -> {0,9,1},{1,2,1}; idx restarts at 0 for second vector.
REQ-035 Reset asserted after beats [6,8] of unfinished vector, then vector [1] -> only {0,1,1} emitted.
REQ-036 With SPARSE_ENCODER_LEN_CHECK_EN, 2^IDX_W+1 beats value 1 -> len_err_o=1 from overflow beat until reset; without macro len_err_o stays 0.
